// File: rtl/rr_mux_arbiter_4_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rr_mux_arbiter_4_pkg
// Description : Shared constants, types and helpers for the 4-source
//               round-robin mux arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package rr_mux_arbiter_4_pkg;

    localparam int NUM_SRC = 4;
    localparam int SEL_W   = 2;

    localparam logic [0:0] ST_EMPTY = 1'b0;
    localparam logic [0:0] ST_FULL  = 1'b1;

    typedef logic [SEL_W-1:0] idx_t;

    // Two-bit wrap is intentional: index 3 rolls over to index 0.
    function automatic idx_t next_idx(input idx_t i);
        return i + idx_t'(1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_mux_arbiter_4_if.sv
`default_nettype none
// ============================================================================
// Module      : rr_mux_arbiter_4_if
// Description : Source-side request/data bus and valid/ready output bus of
//               the round-robin mux arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface rr_mux_arbiter_4_if
    import rr_mux_arbiter_4_pkg::*;
#(
    parameter int N = 4
);
    logic [NUM_SRC-1:0] req;
    logic [N-1:0]       a;
    logic [N-1:0]       b;
    logic [N-1:0]       c;
    logic [N-1:0]       d;
    logic [NUM_SRC-1:0] in_ready;
    logic [SEL_W-1:0]   sel;
    logic [N-1:0]       out_data;
    logic [SEL_W-1:0]   out_src;
    logic               out_valid;
    logic               out_ready;

    modport master (
        output req, a, b, c, d, out_ready,
        input  in_ready, sel, out_data, out_src, out_valid
    );

    modport slave (
        input  req, a, b, c, d, out_ready,
        output in_ready, sel, out_data, out_src, out_valid
    );
endinterface
`default_nettype wire

// File: rtl/mux_4to1.sv
`default_nettype none
// ============================================================================
// Module      : mux_4to1
// Description : Combinational 4:1 multiplexer of N-bit words.
// Revision    : 1.0 - initial release
// ============================================================================
module mux_4to1 #(
    parameter int N = 4
) (
    input  wire logic [N-1:0] a,
    input  wire logic [N-1:0] b,
    input  wire logic [N-1:0] c,
    input  wire logic [N-1:0] d,
    input  wire logic [1:0]   sel,
    output logic      [N-1:0] y
);
    always_comb begin
        y = a;
        case (sel)
            2'd0:    y = a;
            2'd1:    y = b;
            2'd2:    y = c;
            2'd3:    y = d;
            default: y = a;
        endcase
    end
endmodule
`default_nettype wire

// File: rtl/rr_grant_4.sv
`default_nettype none
// ============================================================================
// Module      : rr_grant_4
// Description : Combinational rotating-priority grant over four requests,
//               searching upward from ptr with wrap.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_grant_4
    import rr_mux_arbiter_4_pkg::*;
(
    input  wire logic [NUM_SRC-1:0] req,
    input  wire logic [SEL_W-1:0]   ptr,
    output logic      [SEL_W-1:0]   gnt_idx,
    output logic                    gnt_any
);
    // Scan from the farthest offset down so the nearest set bit writes last.
    always_comb begin
        gnt_idx = ptr;
        gnt_any = |req;
        for (int k = NUM_SRC - 1; k >= 0; k--) begin
            if (req[ptr + SEL_W'(k)]) begin
                gnt_idx = ptr + SEL_W'(k);
            end
        end
    end
endmodule
`default_nettype wire

// File: rtl/rr_mux_arbiter_4.sv
`default_nettype none
// ============================================================================
// Module      : rr_mux_arbiter_4
// Description : Round-robin front end for the 4:1 data mux with a one-deep
//               valid/ready output register.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_mux_arbiter_4
    import rr_mux_arbiter_4_pkg::*;
#(
    parameter int N          = 4,
    parameter bit FIXED_PRIO = 1'b0
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    rr_mux_arbiter_4_if.slave bus
);
    logic [SEL_W-1:0] r_ptr;
    logic [SEL_W-1:0] w_gnt_idx;
    logic [SEL_W-1:0] w_sel;
    logic             w_gnt_any;
    logic             w_load_en;
    logic             w_accept;
    logic [N-1:0]     w_mux_y;
    logic [N-1:0]     r_out_data;
    logic [SEL_W-1:0] r_out_src;
    logic [0:0]       r_state;
    logic [0:0]       w_state_nxt;
    logic             w_out_valid;

    rr_grant_4 u_grant (
        .req     (bus.req),
        .ptr     (r_ptr),
        .gnt_idx (w_gnt_idx),
        .gnt_any (w_gnt_any)
    );

    mux_4to1 #(.N(N)) u_mux (
        .a   (bus.a),
        .b   (bus.b),
        .c   (bus.c),
        .d   (bus.d),
        .sel (w_sel),
        .y   (w_mux_y)
    );

    // Select and accept are masked while reset is held so nothing leaks out.
    assign w_sel     = rst_n ? w_gnt_idx : '0;
    assign w_load_en = !w_out_valid || bus.out_ready;
    assign w_accept  = rst_n && w_load_en && w_gnt_any;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_EMPTY: begin
                if (w_accept) begin
                    w_state_nxt = ST_FULL;
                end
            end
            ST_FULL: begin
                if (bus.out_ready && !w_accept) begin
                    w_state_nxt = ST_EMPTY;
                end
            end
            default: w_state_nxt = ST_EMPTY;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        w_out_valid = (r_state == ST_FULL);
    end

    // Output word and priority pointer only move on an accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_data <= '0;
            r_out_src  <= '0;
        end else if (w_accept) begin
            r_out_data <= w_mux_y;
            r_out_src  <= w_sel;
        end
    end

    generate
        if (FIXED_PRIO) begin : g_ptr_fixed
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_ptr <= '0;
                end else begin
                    r_ptr <= '0;
                end
            end
        end else begin : g_ptr_rr
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_ptr <= '0;
                end else if (w_accept) begin
                    r_ptr <= next_idx(w_sel);
                end
            end
        end
    endgenerate

    assign bus.sel       = w_sel;
    assign bus.in_ready  = w_accept ? ({{(NUM_SRC-1){1'b0}}, 1'b1} << w_sel) : '0;
    assign bus.out_data  = r_out_data;
    assign bus.out_src   = r_out_src;
    assign bus.out_valid = w_out_valid;
endmodule
`default_nettype wire

// File: tb/tb_rr_mux_arbiter_4.sv
`default_nettype none
// ============================================================================
// Module      : tb_rr_mux_arbiter_4
// Description : Directed self-checking bench for rr_mux_arbiter_4, covering
//               round-robin and fixed-priority builds.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rr_mux_arbiter_4;
    localparam int N = 4;

    logic clk;
    logic rst_n;
    logic rst1_n;
    int   errors;
    int   checks;

    rr_mux_arbiter_4_if #(.N(N)) bus  ();
    rr_mux_arbiter_4_if #(.N(N)) bus1 ();

    rr_mux_arbiter_4 #(.N(N), .FIXED_PRIO(1'b0)) u_dut_rr (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    rr_mux_arbiter_4 #(.N(N), .FIXED_PRIO(1'b1)) u_dut_fixed (
        .clk   (clk),
        .rst_n (rst1_n),
        .bus   (bus1.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst_n  = 1'b0;
        rst1_n = 1'b0;
        bus.req = 4'hF; bus.out_ready = 1'b0;
        bus.a = 4'd1; bus.b = 4'd2; bus.c = 4'd3; bus.d = 4'd4;
        bus1.req = 4'h0; bus1.out_ready = 1'b0;
        bus1.a = 4'd6; bus1.b = 4'd0; bus1.c = 4'd0; bus1.d = 4'd7;

        // Reset with all requests pending
        #12;
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_in_ready",  32'(bus.in_ready),  32'd0);
        chk("rst_sel",       32'(bus.sel),       32'd0);
        chk("rst_out_data",  32'(bus.out_data),  32'd0);
        chk("rst_out_src",   32'(bus.out_src),   32'd0);

        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        #1;
        chk("first_in_ready", 32'(bus.in_ready), 32'h1);
        chk("first_sel",      32'(bus.sel),      32'd0);

        // Round-robin at full throughput: src 0,1,2,3,0
        for (int i = 0; i < 5; i++) begin
            step();
            chk("rr_valid", 32'(bus.out_valid), 32'd1);
            chk("rr_src",   32'(bus.out_src),   32'(i % 4));
            chk("rr_data",  32'(bus.out_data),  32'((i % 4) + 1));
        end

        // Back-pressure: load 0x5 from src1, then stall three cycles
        bus.b = 4'd5;
        step();
        chk("bp_load_data", 32'(bus.out_data), 32'h5);
        chk("bp_load_src",  32'(bus.out_src),  32'd1);
        bus.out_ready = 1'b0;
        #1;
        chk("bp_in_ready0", 32'(bus.in_ready), 32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("bp_hold_data",  32'(bus.out_data),  32'h5);
            chk("bp_hold_src",   32'(bus.out_src),   32'd1);
            chk("bp_hold_valid", 32'(bus.out_valid), 32'd1);
            chk("bp_in_ready",   32'(bus.in_ready),  32'd0);
            chk("bp_ptr_sel",    32'(bus.sel),       32'd2);
        end
        bus.out_ready = 1'b1;
        #1;
        chk("bp_release_in_ready", 32'(bus.in_ready), 32'h4);
        step();
        chk("bp_release_src",  32'(bus.out_src),  32'd2);
        chk("bp_release_data", 32'(bus.out_data), 32'd3);

        // Sparse requests with pointer wrap from 3
        bus.req = 4'b0101;
        #1;
        chk("sp_sel_wrap",      32'(bus.sel),      32'd0);
        chk("sp_in_ready_wrap", 32'(bus.in_ready), 32'h1);
        step();
        chk("sp_src0",  32'(bus.out_src),  32'd0);
        chk("sp_data0", 32'(bus.out_data), 32'd1);
        chk("sp_sel2",  32'(bus.sel),      32'd2);
        step();
        chk("sp_src2",  32'(bus.out_src),  32'd2);
        chk("sp_data2", 32'(bus.out_data), 32'd3);
        bus.req = 4'b0000;
        #1;
        chk("idle_in_ready", 32'(bus.in_ready), 32'd0);
        chk("idle_sel_ptr",  32'(bus.sel),      32'd3);
        step();
        chk("drain_valid", 32'(bus.out_valid), 32'd0);
        chk("drain_data",  32'(bus.out_data),  32'd3);
        chk("drain_src",   32'(bus.out_src),   32'd2);
        step();
        chk("idle_no_rotate", 32'(bus.sel), 32'd3);

        // Async reset while FULL and stalled
        bus.req = 4'hF;
        bus.out_ready = 1'b0;
        step();
        chk("ar_valid", 32'(bus.out_valid), 32'd1);
        chk("ar_src",   32'(bus.out_src),   32'd3);
        chk("ar_data",  32'(bus.out_data),  32'd4);
        step();
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_async_valid",    32'(bus.out_valid), 32'd0);
        chk("ar_async_data",     32'(bus.out_data),  32'd0);
        chk("ar_async_in_ready", 32'(bus.in_ready),  32'd0);
        chk("ar_async_sel",      32'(bus.sel),       32'd0);
        rst_n = 1'b1;

        // Fixed priority: src0 always beats src3
        bus1.req = 4'b1001;
        bus1.out_ready = 1'b1;
        #3;
        rst1_n = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) begin
            chk("fp_in_ready", 32'(bus1.in_ready), 32'h1);
            chk("fp_sel",      32'(bus1.sel),      32'd0);
            step();
            chk("fp_src",   32'(bus1.out_src),   32'd0);
            chk("fp_data",  32'(bus1.out_data),  32'd6);
            chk("fp_valid", 32'(bus1.out_valid), 32'd1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end
endmodule
`default_nettype wire
